alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Parametrised R-type execute unit: decodes opcode/funct3/funct7 into an internal ALU control code and produces the result.
- Single-cycle ops: ADD, SUB, AND, OR, XOR, SLT, SLTU.
- Multi-cycle ops (RV32M subset): MUL (low word), DIV, DIVU, REM, REMU, computed iteratively.
- Sits in EX stage; valid/ready handshake on both sides lets the pipeline stall on long ops.

Parameters:
XLEN, 32, operand/result width (>=8, even)
MUL_BITS_PER_CYC, 1, multiplier bits retired per iteration (1, 2 or 4; must divide XLEN)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation offered
in_ready  output  1  unit can accept
opcode  input  7  instruction opcode
funct3  input  3  instruction funct3
funct7  input  7  instruction funct7
rs1  input  XLEN  operand A
rs2  input  XLEN  operand B
out_valid  output  1  result available
out_ready  input  1  consumer takes result
result  output  XLEN  result value
illegal  output  1  qualifies out_valid: op not decodable, result = 0

Behaviour:
- Reset (async assert, sync deassert): state IDLE; in_ready=1; out_valid=0; result=0; illegal=0; iteration counter=0.
- States: IDLE, MUL, DIV, DONE.
- in_ready=1 only in IDLE. Accept = in_valid & in_ready. Operands and decoded control are captured at accept; inputs are don't-care afterwards.
- Decode (opcode must be 7'b0110011, else illegal):
  - funct7=0000000: f3 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT, 011 SLTU; other f3 illegal.
  - funct7=0100000: f3 000 SUB; other f3 illegal.
  - funct7=0000001: f3 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU; 001/010/011 illegal.
  - Any other funct7: illegal.
- Single-cycle and illegal ops: IDLE -> DONE on accept; out_valid=1 the next cycle (latency 1).
- MUL: IDLE -> MUL. Shift-add, MUL_BITS_PER_CYC bits per cycle, XLEN/MUL_BITS_PER_CYC cycles, then -> DONE. Result is the low XLEN bits; sign-agnostic.
- DIV/DIVU/REM/REMU: IDLE -> DIV. Restoring divide on magnitudes, one quotient bit per cycle, XLEN cycles, then -> DONE.
  - Signed ops: quotient negated if operand signs differ; remainder takes the dividend's sign.
- Divide special cases, resolved at accept with latency 1 (no iteration):
  - rs2=0: quotient = all-ones; remainder = rs1.
  - Signed overflow (rs1 = MIN, rs2 = -1): quotient = MIN; remainder = 0.
- DONE: result, illegal and out_valid held stable until out_ready. On out_valid & out_ready -> IDLE; in_ready rises the following cycle, so there is no same-cycle re-accept.
- Back-to-back single-cycle throughput: one op per 2 cycles.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN. SLT/SLTU return zero-extended 0 or 1.
- Reset mid-operation aborts immediately. No partial result, no spurious out_valid.
- in_valid while not in_ready is ignored; the producer must hold it.

Decomposition:
- Package alu_exec_pkg:
  - alu_ctrl_e enum: ADD, SUB, AND, OR, XOR, SLT, SLTU, MUL, DIV, DIVU, REM, REMU, ILLEGAL.
  - state_e enum.
  - Constants OPC_RTYPE, F7_BASE, F7_ALT, F7_MULDIV.
- Sub-module alu_div_iter: sequential restoring divider with start/done, unsigned XLEN, instantiated for the DIV state.
- Decode and multiplier stay in the top module.

Test Plan:
- ADD rs1=0x7FFFFFFF, rs2=1 -> out_valid 1 cycle after accept, result=0x80000000, illegal=0; SUB 5-7 -> 0xFFFFFFFE.
- SLT rs1=0xFFFFFFFF, rs2=1 -> 1; SLTU with same operands -> 0.
- MUL rs1=0xFFFFFFFD (-3), rs2=7 -> result=0xFFFFFFEB after exactly XLEN+1 cycles (33 at XLEN=32, MUL_BITS_PER_CYC=1); repeat with MUL_BITS_PER_CYC=4 -> 9 cycles.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF at latency 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- funct7=0000001 with funct3=001, and opcode=0010011 -> illegal=1, result=0, latency 1.
- Hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0; then rst_n pulsed during a DIV iteration -> out_valid=0, in_ready=1, next op correct.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared types and decode helper for the R-type execute unit.
package alu_exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU,
    ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_ILLEGAL
  } alu_ctrl_e;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  function automatic alu_ctrl_e alu_decode(input logic [6:0] opc,
                                           input logic [2:0] f3,
                                           input logic [6:0] f7);
    alu_ctrl_e c;
    c = ALU_ILLEGAL;
    if (opc == OPC_RTYPE) begin
      case (f7)
        F7_BASE: begin
          case (f3)
            3'b000:  c = ALU_ADD;
            3'b111:  c = ALU_AND;
            3'b110:  c = ALU_OR;
            3'b100:  c = ALU_XOR;
            3'b010:  c = ALU_SLT;
            3'b011:  c = ALU_SLTU;
            default: c = ALU_ILLEGAL;
          endcase
        end
        F7_ALT:    c = (f3 == 3'b000) ? ALU_SUB : ALU_ILLEGAL;
        F7_MULDIV: begin
          case (f3)
            3'b000:  c = ALU_MUL;
            3'b100:  c = ALU_DIV;
            3'b101:  c = ALU_DIVU;
            3'b110:  c = ALU_REM;
            3'b111:  c = ALU_REMU;
            default: c = ALU_ILLEGAL;
          endcase
        end
        default:   c = ALU_ILLEGAL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle, XLEN cycles per divide.
// o_done flags the final iteration; o_quotient/o_remainder then carry the finished values.
module alu_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);
  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_fits;

  always_comb begin
    w_shift     = {r_rem, r_quo[XLEN-1]};
    w_diff      = w_shift - {1'b0, r_dvs};
    w_fits      = ~w_diff[XLEN];
    o_quotient  = {r_quo[XLEN-2:0], w_fits};
    o_remainder = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  end

  assign o_done = r_busy & (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_dvs  <= i_divisor;
      r_cnt  <= CW'(XLEN);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_quo  <= o_quotient;
      r_rem  <= o_remainder;
      r_cnt  <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// R-type execute unit: single-cycle ALU ops plus iterative MUL and DIV/REM.
//   state   | meaning
//   IDLE    | ready to accept an op
//   MUL     | shift-add multiply in progress
//   DIV     | restoring divide in progress (alu_div_iter busy)
//   DONE    | result held until out_ready
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int MUL_BITS_PER_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);
  localparam int              CW        = $clog2(XLEN + 1);
  localparam int              MUL_ITERS = XLEN / MUL_BITS_PER_CYC;
  localparam logic [XLEN-1:0] MIN_VAL   = {1'b1, {(XLEN-1){1'b0}}};

  state_e          r_state, w_next;
  alu_ctrl_e       r_ctrl, w_ctrl;
  logic [XLEN-1:0] r_result, r_mcand, r_mplier, r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_illegal, r_neg_q, r_neg_r;
  logic            w_accept, w_is_mul, w_is_div, w_signed_div;
  logic            w_div_ovf, w_div_special, w_div_start, w_div_done;
  logic [XLEN-1:0] w_fast, w_abs_a, w_abs_b, w_acc_nxt, w_quo, w_rem, w_div_res;

  always_comb begin
    w_ctrl        = alu_decode(opcode, funct3, funct7);
    w_accept      = in_valid & in_ready;
    w_is_mul      = (w_ctrl == ALU_MUL);
    w_is_div      = (w_ctrl == ALU_DIV) | (w_ctrl == ALU_DIVU) |
                    (w_ctrl == ALU_REM) | (w_ctrl == ALU_REMU);
    w_signed_div  = (w_ctrl == ALU_DIV) | (w_ctrl == ALU_REM);
    w_div_ovf     = w_signed_div & (rs1 == MIN_VAL) & (rs2 == '1);
    w_div_special = w_is_div & ((rs2 == '0) | w_div_ovf);
    w_div_start   = w_accept & w_is_div & ~w_div_special;
    w_abs_a       = (w_signed_div & rs1[XLEN-1]) ? -rs1 : rs1;
    w_abs_b       = (w_signed_div & rs2[XLEN-1]) ? -rs2 : rs2;
  end

  // Single-cycle results, divide special cases, and zero for illegal ops.
  always_comb begin
    w_fast = '0;
    case (w_ctrl)
      ALU_ADD:            w_fast = rs1 + rs2;
      ALU_SUB:            w_fast = rs1 - rs2;
      ALU_AND:            w_fast = rs1 & rs2;
      ALU_OR:             w_fast = rs1 | rs2;
      ALU_XOR:            w_fast = rs1 ^ rs2;
      ALU_SLT:            w_fast = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      ALU_SLTU:           w_fast = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
      ALU_DIV, ALU_DIVU:  w_fast = w_div_ovf ? MIN_VAL : '1;
      ALU_REM, ALU_REMU:  w_fast = w_div_ovf ? '0 : rs1;
      default:            w_fast = '0;
    endcase
  end

  always_comb begin
    w_acc_nxt = r_acc;
    for (int b = 0; b < MUL_BITS_PER_CYC; b++) begin
      if (r_mplier[b]) w_acc_nxt = w_acc_nxt + (r_mcand << b);
    end
  end

  alu_div_iter #(.XLEN(XLEN)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_div_start),
    .i_dividend  (w_abs_a),
    .i_divisor   (w_abs_b),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  assign w_div_res = ((r_ctrl == ALU_DIV) | (r_ctrl == ALU_DIVU)) ?
                     (r_neg_q ? -w_quo : w_quo) : (r_neg_r ? -w_rem : w_rem);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_next = w_is_mul ? ST_MUL :
                                      (w_is_div & ~w_div_special) ? ST_DIV : ST_DONE;
      ST_MUL:  if (r_cnt == CW'(1)) w_next = ST_DONE;
      ST_DIV:  if (w_div_done) w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
    result    = r_result;
    illegal   = r_illegal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= ALU_ILLEGAL;
      r_result  <= '0;
      r_illegal <= 1'b0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else if (w_accept) begin
      r_ctrl    <= w_ctrl;
      r_illegal <= (w_ctrl == ALU_ILLEGAL);
      r_result  <= w_fast;
      r_mcand   <= rs1;
      r_mplier  <= rs2;
      r_acc     <= '0;
      r_cnt     <= w_is_mul ? CW'(MUL_ITERS) : '0;
      r_neg_q   <= w_signed_div & (rs1[XLEN-1] ^ rs2[XLEN-1]);
      r_neg_r   <= w_signed_div & rs1[XLEN-1];
    end else if (r_state == ST_MUL) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << MUL_BITS_PER_CYC;
      r_mplier <= r_mplier >> MUL_BITS_PER_CYC;
      r_cnt    <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) r_result <= w_acc_nxt;
    end else if ((r_state == ST_DIV) && w_div_done) begin
      r_result <= w_div_res;
    end
  end

endmodule
